vga_capture: RTL and testbench



---
 rtl/vga_capture.sv | 211 +++++++++++++++++++++
 tb/tb_vga_capture.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_capture.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : vga_capture
//  Purpose  : Samples a VGA pixel stream (hsync/vsync/RGB444), locks to the
//             frame timing and forwards active-window pixels as a 16-bit
//             AXI4-Stream through a small FIFO with sticky overflow.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_capture #(
  parameter int hActiveArea = 640,
  parameter int hFrontPorch = 16,
  parameter int hSyncPulse  = 96,
  parameter int hBackPorch  = 48,
  parameter int vActiveArea = 480,
  parameter int vFrontPorch = 11,
  parameter int vSyncPulse  = 2,
  parameter int vBackPorch  = 31,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic        clk25,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  red,
  input  logic [3:0]  green,
  input  logic [3:0]  blue,
  output logic [15:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tuser,
  output logic        m_tlast,
  input  logic        clear_ovf,
  output logic        overflow,
  output logic        locked
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // Active window bounds in counter coordinates (hc/vc = 0 at sync fall).
  localparam logic [9:0] C_H_START = 10'(hSyncPulse + hBackPorch);
  localparam logic [9:0] C_H_END   = 10'(hSyncPulse + hBackPorch + hActiveArea);
  localparam logic [9:0] C_H_LAST  = C_H_END - 10'd1;
  localparam logic [9:0] C_V_START = 10'(vSyncPulse + vBackPorch);
  localparam logic [9:0] C_V_END   = 10'(vSyncPulse + vBackPorch + vActiveArea);
  localparam logic [9:0] C_CNT_MAX = 10'd1023;

  // Capture is disabled outright if the timing cannot fit the 10-bit
  // counters or the FIFO depth is not a power of two of at least 4.
  localparam logic C_PARAMS_OK =
      ((hSyncPulse + hBackPorch + hActiveArea + hFrontPorch) <= 1024) &&
      ((vSyncPulse + vBackPorch + vActiveArea + vFrontPorch) <= 1024) &&
      (FIFO_DEPTH >= 4) && ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0);

  localparam logic [AW:0]   C_DEPTH   = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   C_CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] C_PTR_ONE = AW'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DROP    = 2'd2
  } state_t;

  // Input stage and one-sample history for edge detection
  logic       hs_q, vs_q, hs_prev_q, vs_prev_q;
  logic [3:0] red_q, green_q, blue_q;

  // Timing counters, lock, overflow, FSM
  logic [9:0] hc_q, hc_d, vc_q, vc_d;
  logic       locked_q, locked_d;
  logic       ovf_q, ovf_d;
  state_t     state_q, state_d;

  // FIFO
  logic [17:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [17:0]   head;

  logic hfall, vfall, active, sof, eol, full, push, drop, pop;
  logic [15:0] pix_packed;

  // Register the raw video inputs and keep the previous sync samples.
  always_ff @(posedge clk25) begin
    if (reset) begin
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      hs_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
      red_q     <= 4'd0;
      green_q   <= 4'd0;
      blue_q    <= 4'd0;
    end else begin
      hs_q      <= hsync;
      vs_q      <= vsync;
      hs_prev_q <= hs_q;
      vs_prev_q <= vs_q;
      red_q     <= red;
      green_q   <= green;
      blue_q    <= blue;
    end
  end

  // Position of the sample currently held in the input stage; hc_q/vc_q
  // hold the position of the previous sample.
  always_comb begin
    hfall = hs_prev_q & ~hs_q;
    vfall = vs_prev_q & ~vs_q;
    hc_d  = hfall ? 10'd0 : ((hc_q == C_CNT_MAX) ? hc_q : hc_q + 10'd1);
    vc_d  = vc_q;
    if (hfall) begin
      vc_d = vfall ? 10'd0 : ((vc_q == C_CNT_MAX) ? vc_q : vc_q + 10'd1);
    end
    active = C_PARAMS_OK &&
             (hc_d >= C_H_START) && (hc_d < C_H_END) &&
             (vc_d >= C_V_START) && (vc_d < C_V_END);
    sof        = (hc_d == C_H_START) && (vc_d == C_V_START);
    eol        = (hc_d == C_H_LAST);
    pix_packed = {red_q, 1'b0, green_q, 2'b00, blue_q, 1'b0};
    locked_d   = locked_q | vfall;
  end

  // Capture FSM: decides whether the current active sample is pushed,
  // dropped on a full FIFO, or skipped while resynchronising to a frame.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    drop    = 1'b0;
    full    = (count_q == C_DEPTH);
    unique case (state_q)
      ST_IDLE: begin
        if (locked_q) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (active) begin
          if (full) begin
            drop    = 1'b1;
            state_d = ST_DROP;
          end else begin
            push = 1'b1;
          end
        end
      end
      ST_DROP: begin
        if (active && sof) begin
          if (full) begin
            drop = 1'b1;
          end else begin
            push    = 1'b1;
            state_d = ST_CAPTURE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO occupancy, pop handshake and overflow flag next state.
  always_comb begin
    pop     = (count_q != '0) & m_tready;
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + C_CNT_ONE;
      2'b01:   count_d = count_q - C_CNT_ONE;
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q;
    if (drop)           ovf_d = 1'b1;
    else if (clear_ovf) ovf_d = 1'b0;
  end

  // Control state: counters, lock, overflow, FSM and FIFO pointers.
  always_ff @(posedge clk25) begin
    if (reset) begin
      hc_q     <= 10'd0;
      vc_q     <= 10'd0;
      locked_q <= 1'b0;
      ovf_q    <= 1'b0;
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      hc_q     <= hc_d;
      vc_q     <= vc_d;
      locked_q <= locked_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      count_q  <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + C_PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + C_PTR_ONE;
    end
  end

  // FIFO storage: {tlast, tuser, tdata}; contents need no reset because
  // the outputs are gated by the occupancy count.
  always_ff @(posedge clk25) begin
    if (push) mem_q[wr_ptr_q] <= {eol, sof, pix_packed};
  end

  assign head     = mem_q[rd_ptr_q];
  assign m_tvalid = (count_q != '0);
  assign m_tdata  = m_tvalid ? head[15:0] : 16'd0;
  assign m_tuser  = m_tvalid & head[16];
  assign m_tlast  = m_tvalid & head[17];
  assign overflow = ovf_q;
  assign locked   = locked_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_capture.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_vga_capture
//  Purpose  : Directed self-checking bench for vga_capture using a reduced
//             video timing (17 x 8 frame, 10 x 4 active window).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_capture;

  localparam int H_SP = 3, H_BP = 2, H_ACT = 10, H_FP = 2;
  localparam int V_SP = 1, V_BP = 2, V_ACT = 4,  V_FP = 1;
  localparam int H_TOT = H_SP + H_BP + H_ACT + H_FP;  // 17, active h = 5..14
  localparam int V_TOT = V_SP + V_BP + V_ACT + V_FP;  // 8,  active v = 3..6
  localparam int PIX   = H_ACT * V_ACT;               // 40 pixels per frame

  localparam int M_PLAIN = 0, M_LOCK = 1, M_LAT = 2, M_OVF = 3, M_RST = 4, M_LOSS = 5;

  logic        clk25 = 1'b0;
  logic        reset, hsync, vsync, m_tready, clear_ovf;
  logic [3:0]  red, green, blue;
  logic [15:0] m_tdata;
  logic        m_tvalid, m_tuser, m_tlast, overflow, locked;

  logic [3:0]  col_r, col_g, col_b;
  logic        vs_en;
  logic [17:0] beats_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  vga_capture #(
    .hActiveArea(H_ACT), .hFrontPorch(H_FP), .hSyncPulse(H_SP), .hBackPorch(H_BP),
    .vActiveArea(V_ACT), .vFrontPorch(V_FP), .vSyncPulse(V_SP), .vBackPorch(V_BP),
    .FIFO_DEPTH(16)
  ) u_dut (
    .clk25(clk25), .reset(reset), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tuser(m_tuser), .m_tlast(m_tlast),
    .clear_ovf(clear_ovf), .overflow(overflow), .locked(locked)
  );

  always #5 clk25 = ~clk25;

  // Record every accepted beat away from the active edge.
  always @(negedge clk25) begin
    if (!reset && m_tvalid && m_tready) beats_q.push_back({m_tlast, m_tuser, m_tdata});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_sample(input int line, input int h);
    hsync = (h < H_SP) ? 1'b0 : 1'b1;
    vsync = (vs_en && line < V_SP) ? 1'b0 : 1'b1;
    red   = col_r;
    green = col_g;
    blue  = col_b;
    @(posedge clk25);
    #1;
  endtask

  task automatic idle(input int n);
    hsync = 1'b1;
    vsync = 1'b1;
    repeat (n) @(posedge clk25);
    #1;
  endtask

  // Beats in the queue: constant data, tuser on beat 0, tlast every H_ACT.
  task automatic check_queue(input string tag, input logic [15:0] exp_data, input int exp_n);
    int bad_d = 0;
    int bad_u = 0;
    int bad_l = 0;
    check({tag, " beats"}, beats_q.size(), exp_n);
    foreach (beats_q[i]) begin
      if (beats_q[i][15:0] !== exp_data)          bad_d++;
      if (beats_q[i][16] !== (i == 0))            bad_u++;
      if (beats_q[i][17] !== ((i % H_ACT) == H_ACT - 1)) bad_l++;
    end
    check({tag, " bad_data"}, bad_d, 0);
    check({tag, " bad_tuser"}, bad_u, 0);
    check({tag, " bad_tlast"}, bad_l, 0);
    beats_q.delete();
  endtask

  // One full frame; some modes inject controls or probe specific samples.
  task automatic drive_frame(input int mode);
    for (int line = 0; line < V_TOT; line++) begin
      if (mode == M_LOSS && line == 3) return;
      for (int h = 0; h < H_TOT; h++) begin
        if (mode == M_OVF) clear_ovf = (line == 4) && (h == 12 || h == 13);
        if (mode == M_RST) reset = (line == 4) && (h == 0);
        drive_sample(line, h);
        if (mode == M_LOCK && line == 0) begin
          if (h == 0) check("lock_not_yet", locked, 1'b0);
          if (h == 1) check("lock_set", locked, 1'b1);
        end
        if (mode == M_LAT && line == 3) begin
          if (h == 5)  check("lat_before", m_tvalid, 1'b0);
          if (h == 6) begin
            check("lat_valid", m_tvalid, 1'b1);
            check("lat_tuser", m_tuser, 1'b1);
            check("lat_tdata", m_tdata, 16'h3602);
          end
          if (h == 14) check("lat_tlast_early", m_tlast, 1'b0);
          if (h == 15) check("lat_tlast", m_tlast, 1'b1);
          if (h == 16) check("lat_drained", m_tvalid, 1'b0);
        end
        if (mode == M_OVF && line == 4) begin
          if (h == 11) check("ovf_16_held", overflow, 1'b0);
          if (h == 12) begin
            check("ovf_set_wins", overflow, 1'b1);
            check("ovf_hold_tdata", m_tdata, 16'hA29E);
            check("ovf_hold_tuser", m_tuser, 1'b1);
          end
          if (h == 13) check("ovf_cleared", overflow, 1'b0);
        end
        if (mode == M_RST && line == 3 && h == 16) check("rst_queued", m_tvalid, 1'b1);
        if (mode == M_RST && line == 4 && h == 0) begin
          check("rst_tvalid", m_tvalid, 1'b0);
          check("rst_locked", locked, 1'b0);
        end
      end
    end
    clear_ovf = 1'b0;
    reset     = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; hsync = 1'b1; vsync = 1'b1; m_tready = 1'b0; clear_ovf = 1'b0;
    red = 4'd0; green = 4'd0; blue = 4'd0;
    col_r = 4'hA; col_g = 4'h5; col_b = 4'hF; vs_en = 1'b0;
    repeat (3) @(posedge clk25);
    #1;
    check("reset_tvalid", m_tvalid, 1'b0);
    check("reset_tuser", m_tuser, 1'b0);
    check("reset_tlast", m_tlast, 1'b0);
    check("reset_tdata", m_tdata, 16'h0000);
    check("reset_overflow", overflow, 1'b0);
    check("reset_locked", locked, 1'b0);
    reset    = 1'b0;
    m_tready = 1'b1;

    // Frame without vsync: nothing may be captured.
    drive_frame(M_PLAIN);
    check("nolock_beats", beats_q.size(), 0);
    check("nolock_locked", locked, 1'b0);

    // First vsync fall locks; second frame is the reference frame.
    vs_en = 1'b1;
    drive_frame(M_LOCK);
    beats_q.delete();
    drive_frame(M_PLAIN);
    check_queue("frame2", 16'hA29E, PIX);
    check("frame2_overflow", overflow, 1'b0);

    // Latency and line-end flags with a different colour.
    col_r = 4'h3; col_g = 4'hC; col_b = 4'h1;
    drive_frame(M_LAT);
    check_queue("lat_frame", 16'h3602, PIX);

    // Back-pressure: 16 held, 17th overflows, drop until next frame start.
    col_r = 4'hA; col_g = 4'h5; col_b = 4'hF;
    m_tready = 1'b0;
    drive_frame(M_OVF);
    check("ovf_after_frame", overflow, 1'b0);
    check("ovf_pending", m_tvalid, 1'b1);
    check("ovf_no_beats", beats_q.size(), 0);
    m_tready = 1'b1;
    idle(30);
    check_queue("ovf_drain", 16'hA29E, 16);
    drive_frame(M_PLAIN);
    check_queue("ovf_resume", 16'hA29E, PIX);

    // Sync loss: counters saturate, no pushes, recovery on next frame.
    drive_frame(M_LOSS);
    idle(1100);
    check("loss_beats", beats_q.size(), 0);
    drive_frame(M_PLAIN);
    check_queue("loss_recover", 16'hA29E, PIX);

    // Mid-frame reset with 10 entries queued.
    m_tready = 1'b0;
    drive_frame(M_RST);
    check("rst_no_output", m_tvalid, 1'b0);
    check("rst_still_unlocked", locked, 1'b0);
    check("rst_no_beats", beats_q.size(), 0);
    m_tready = 1'b1;
    drive_frame(M_PLAIN);
    check_queue("rst_resume", 16'hA29E, PIX);
    check("rst_relocked", locked, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
